// File: rtl/udma_hyper_reg_if_multich.sv
// Multi-channel uDMA HyperBus register file: N_CH register banks, a shared
// kick FIFO of {channel, direction} descriptors, and head-of-queue config mux.
module udma_hyper_reg_if_multich #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int N_CH           = 4,
  parameter int QUEUE_DEPTH    = 4,
  localparam int CH_W          = $clog2(N_CH),
  localparam int CNT_W         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [5+CH_W-1:0]         cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic                      trans_valid_o,
  input  logic                      trans_ready_i,
  output logic [CH_W-1:0]           trans_id_o,
  output logic                      trans_rx_o,
  input  logic                      busy_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_size_o,
  output logic                      cfg_continuous_o,
  output logic [31:0]               cfg_hyper_addr_o,
  output logic [15:0]               cfg_hyper_intreg_o,
  output logic                      cfg_rw_hyper_o,
  output logic                      cfg_addr_space_o,
  output logic                      cfg_burst_type_o,
  output logic                      cfg_twd_ext_act_o,
  output logic [TRANS_SIZE-1:0]     cfg_twd_ext_count_o,
  output logic [TRANS_SIZE-1:0]     cfg_twd_ext_stride_o,
  output logic                      cfg_twd_l2_act_o,
  output logic [TRANS_SIZE-1:0]     cfg_twd_l2_count_o,
  output logic [TRANS_SIZE-1:0]     cfg_twd_l2_stride_o,
  output logic [N_CH-1:0]           cfg_rx_clr_o,
  output logic [N_CH-1:0]           cfg_tx_clr_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  localparam logic [4:0] R_RX_SADDR   = 5'h00;
  localparam logic [4:0] R_RX_SIZE    = 5'h01;
  localparam logic [4:0] R_RXCFG      = 5'h02;
  localparam logic [4:0] R_TX_SADDR   = 5'h03;
  localparam logic [4:0] R_TX_SIZE    = 5'h04;
  localparam logic [4:0] R_TXCFG      = 5'h05;
  localparam logic [4:0] R_CA_SETUP   = 5'h06;
  localparam logic [4:0] R_HYPER_ADDR = 5'h07;
  localparam logic [4:0] R_HYPER_CFG  = 5'h08;
  localparam logic [4:0] R_STATUS     = 5'h09;
  localparam logic [4:0] R_EXT_ACT    = 5'h0A;
  localparam logic [4:0] R_EXT_COUNT  = 5'h0B;
  localparam logic [4:0] R_EXT_STRIDE = 5'h0C;
  localparam logic [4:0] R_L2_ACT     = 5'h0D;
  localparam logic [4:0] R_L2_COUNT   = 5'h0E;
  localparam logic [4:0] R_L2_STRIDE  = 5'h0F;

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0] rx_saddr;
    logic [TRANS_SIZE-1:0]     rx_size;
    logic                      rx_cont;
    logic [L2_AWIDTH_NOAL-1:0] tx_saddr;
    logic [TRANS_SIZE-1:0]     tx_size;
    logic                      tx_cont;
    logic                      rw;
    logic                      space;
    logic                      burst;
    logic [31:0]               hyper_addr;
    logic [15:0]               hyper_cfg;
    logic                      ext_act;
    logic [TRANS_SIZE-1:0]     ext_count;
    logic [TRANS_SIZE-1:0]     ext_stride;
    logic                      l2_act;
    logic [TRANS_SIZE-1:0]     l2_count;
    logic [TRANS_SIZE-1:0]     l2_stride;
  } bank_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rx;
  } desc_t;

  localparam bank_t BANK_RST = '{rw: 1'b1, burst: 1'b1, default: '0};

  bank_t            bank_q [N_CH];
  bank_t            bank_d [N_CH];
  desc_t            fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic             err_q, err_d;
  logic [N_CH-1:0]  rx_clr_q, rx_clr_d, tx_clr_q, tx_clr_d;

  logic [CH_W-1:0]  acc_ch;
  logic [4:0]       reg_idx;
  logic             ch_ok, q_empty, q_full, pop, push;
  logic             is_cfg_reg, kick_req, kick_ok, wr_acc, lockable;
  desc_t            head;
  bank_t            hb, rd_bank;

  assign acc_ch  = cfg_addr_i[5+CH_W-1:5];
  assign reg_idx = cfg_addr_i[4:0];
  assign ch_ok   = (int'(acc_ch) < N_CH);

  assign q_empty       = (count_q == '0);
  assign q_full        = (count_q == CNT_W'(QUEUE_DEPTH));
  assign head          = q_empty ? '0 : fifo_q[rd_ptr_q];
  assign trans_valid_o = ~q_empty;
  assign pop           = trans_valid_o & trans_ready_i;

  // Only a kick that cannot find room stalls the APB side; a same-cycle pop makes room.
  assign is_cfg_reg  = (reg_idx == R_RXCFG) | (reg_idx == R_TXCFG);
  assign kick_req    = cfg_valid_i & ~cfg_rwn_i & ch_ok & is_cfg_reg & cfg_data_i[4];
  assign cfg_ready_o = ~(kick_req & q_full & ~pop);
  assign wr_acc      = cfg_valid_i & cfg_ready_o & ~cfg_rwn_i & ch_ok;
  assign kick_ok     = ~pending_q[acc_ch] | (pop & (head.ch == acc_ch));
  assign push        = wr_acc & is_cfg_reg & cfg_data_i[4] & kick_ok;

  always_comb begin
    case (reg_idx)
      R_RX_SADDR, R_RX_SIZE, R_TX_SADDR, R_TX_SIZE, R_CA_SETUP, R_HYPER_ADDR,
      R_HYPER_CFG, R_EXT_ACT, R_EXT_COUNT, R_EXT_STRIDE, R_L2_ACT, R_L2_COUNT,
      R_L2_STRIDE: lockable = 1'b1;
      default:     lockable = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    bank_d    = bank_q;
    pending_d = pending_q;
    err_d     = err_q;
    rx_clr_d  = '0;
    tx_clr_d  = '0;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    // Pop clears before push sets, so a re-kick of the popping channel stays pending.
    if (pop)  pending_d[head.ch] = 1'b0;
    if (push) pending_d[acc_ch]  = 1'b1;
    if (wr_acc) begin
      if (lockable && pending_q[acc_ch]) begin
        err_d = 1'b1;
      end else begin
        case (reg_idx)
          R_RX_SADDR:   bank_d[acc_ch].rx_saddr   = cfg_data_i[L2_AWIDTH_NOAL-1:0];
          R_RX_SIZE:    bank_d[acc_ch].rx_size    = cfg_data_i[TRANS_SIZE-1:0];
          R_TX_SADDR:   bank_d[acc_ch].tx_saddr   = cfg_data_i[L2_AWIDTH_NOAL-1:0];
          R_TX_SIZE:    bank_d[acc_ch].tx_size    = cfg_data_i[TRANS_SIZE-1:0];
          R_CA_SETUP: begin
            bank_d[acc_ch].rw    = cfg_data_i[2];
            bank_d[acc_ch].space = cfg_data_i[1];
            bank_d[acc_ch].burst = cfg_data_i[0];
          end
          R_HYPER_ADDR: bank_d[acc_ch].hyper_addr = cfg_data_i;
          R_HYPER_CFG:  bank_d[acc_ch].hyper_cfg  = cfg_data_i[15:0];
          R_EXT_ACT:    bank_d[acc_ch].ext_act    = cfg_data_i[0];
          R_EXT_COUNT:  bank_d[acc_ch].ext_count  = cfg_data_i[TRANS_SIZE-1:0];
          R_EXT_STRIDE: bank_d[acc_ch].ext_stride = cfg_data_i[TRANS_SIZE-1:0];
          R_L2_ACT:     bank_d[acc_ch].l2_act     = cfg_data_i[0];
          R_L2_COUNT:   bank_d[acc_ch].l2_count   = cfg_data_i[TRANS_SIZE-1:0];
          R_L2_STRIDE:  bank_d[acc_ch].l2_stride  = cfg_data_i[TRANS_SIZE-1:0];
          R_RXCFG: begin
            bank_d[acc_ch].rx_cont = cfg_data_i[0];
            rx_clr_d[acc_ch]       = cfg_data_i[5];
            if (cfg_data_i[4] && !kick_ok) err_d = 1'b1;
          end
          R_TXCFG: begin
            bank_d[acc_ch].tx_cont = cfg_data_i[0];
            tx_clr_d[acc_ch]       = cfg_data_i[5];
            if (cfg_data_i[4] && !kick_ok) err_d = 1'b1;
          end
          R_STATUS: if (cfg_data_i[15]) err_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) bank_q[i] <= BANK_RST;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      rx_clr_q  <= '0;
      tx_clr_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      rx_clr_q  <= rx_clr_d;
      tx_clr_q  <= tx_clr_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only observed when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{ch: acc_ch, rx: (reg_idx == R_RXCFG)};
  end

  assign rd_bank = bank_q[acc_ch];

  always_comb begin
    cfg_data_o = '0;
    if (ch_ok) begin
      case (reg_idx)
        R_RX_SADDR:   cfg_data_o[L2_AWIDTH_NOAL-1:0] = rd_bank.rx_saddr;
        R_RX_SIZE:    cfg_data_o[TRANS_SIZE-1:0]     = rd_bank.rx_size;
        R_RXCFG:      cfg_data_o[5:0] = {pending_q[acc_ch], 4'b0010, rd_bank.rx_cont};
        R_TX_SADDR:   cfg_data_o[L2_AWIDTH_NOAL-1:0] = rd_bank.tx_saddr;
        R_TX_SIZE:    cfg_data_o[TRANS_SIZE-1:0]     = rd_bank.tx_size;
        R_TXCFG:      cfg_data_o[5:0] = {pending_q[acc_ch], 4'b0010, rd_bank.tx_cont};
        R_CA_SETUP:   cfg_data_o[2:0] = {rd_bank.rw, rd_bank.space, rd_bank.burst};
        R_HYPER_ADDR: cfg_data_o      = rd_bank.hyper_addr;
        R_HYPER_CFG:  cfg_data_o[15:0] = rd_bank.hyper_cfg;
        R_STATUS: begin
          cfg_data_o[16 +: N_CH] = pending_q;
          cfg_data_o[15]         = err_q;
          cfg_data_o[8 +: CNT_W] = count_q;
          cfg_data_o[0]          = busy_i;
        end
        R_EXT_ACT:    cfg_data_o[0] = rd_bank.ext_act;
        R_EXT_COUNT:  cfg_data_o[TRANS_SIZE-1:0] = rd_bank.ext_count;
        R_EXT_STRIDE: cfg_data_o[TRANS_SIZE-1:0] = rd_bank.ext_stride;
        R_L2_ACT:     cfg_data_o[0] = rd_bank.l2_act;
        R_L2_COUNT:   cfg_data_o[TRANS_SIZE-1:0] = rd_bank.l2_count;
        R_L2_STRIDE:  cfg_data_o[TRANS_SIZE-1:0] = rd_bank.l2_stride;
        default: ;
      endcase
    end
  end

  // Head outputs: an empty queue reads as channel 0, TX direction.
  assign hb                   = bank_q[head.ch];
  assign trans_id_o           = head.ch;
  assign trans_rx_o           = head.rx;
  assign cfg_startaddr_o      = head.rx ? hb.rx_saddr : hb.tx_saddr;
  assign cfg_size_o           = head.rx ? hb.rx_size  : hb.tx_size;
  assign cfg_continuous_o     = head.rx ? hb.rx_cont  : hb.tx_cont;
  assign cfg_hyper_addr_o     = hb.hyper_addr;
  assign cfg_hyper_intreg_o   = hb.hyper_cfg;
  assign cfg_rw_hyper_o       = hb.rw;
  assign cfg_addr_space_o     = hb.space;
  assign cfg_burst_type_o     = hb.burst;
  assign cfg_twd_ext_act_o    = hb.ext_act;
  assign cfg_twd_ext_count_o  = hb.ext_count;
  assign cfg_twd_ext_stride_o = hb.ext_stride;
  assign cfg_twd_l2_act_o     = hb.l2_act;
  assign cfg_twd_l2_count_o   = hb.l2_count;
  assign cfg_twd_l2_stride_o  = hb.l2_stride;
  assign cfg_rx_clr_o         = rx_clr_q;
  assign cfg_tx_clr_o         = tx_clr_q;

endmodule

// File: tb/tb_udma_hyper_reg_if_multich.sv
// Scoreboard bench: the stimulus process updates a register-map level model and
// queues expected responses; a negedge monitor compares them with the DUT.
module tb_udma_hyper_reg_if_multich;

  localparam int AW = 12, TS = 16, NCH = 4, QD = 4, CHW = 2;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [31:0]     cfg_data_i = '0;
  logic [5+CHW-1:0] cfg_addr_i = '0;
  logic            cfg_valid_i = 1'b0, cfg_rwn_i = 1'b0;
  logic [31:0]     cfg_data_o;
  logic            cfg_ready_o, trans_valid_o;
  logic            trans_ready_i = 1'b0, busy_i = 1'b0;
  logic [CHW-1:0]  trans_id_o;
  logic            trans_rx_o;
  logic [AW-1:0]   cfg_startaddr_o;
  logic [TS-1:0]   cfg_size_o;
  logic            cfg_continuous_o;
  logic [31:0]     cfg_hyper_addr_o;
  logic [15:0]     cfg_hyper_intreg_o;
  logic            cfg_rw_hyper_o, cfg_addr_space_o, cfg_burst_type_o;
  logic            cfg_twd_ext_act_o, cfg_twd_l2_act_o;
  logic [TS-1:0]   cfg_twd_ext_count_o, cfg_twd_ext_stride_o;
  logic [TS-1:0]   cfg_twd_l2_count_o, cfg_twd_l2_stride_o;
  logic [NCH-1:0]  cfg_rx_clr_o, cfg_tx_clr_o;

  always #5 clk = ~clk;

  udma_hyper_reg_if_multich #(
    .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .N_CH(NCH), .QUEUE_DEPTH(QD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
    .trans_id_o(trans_id_o), .trans_rx_o(trans_rx_o), .busy_i(busy_i),
    .cfg_startaddr_o(cfg_startaddr_o), .cfg_size_o(cfg_size_o),
    .cfg_continuous_o(cfg_continuous_o), .cfg_hyper_addr_o(cfg_hyper_addr_o),
    .cfg_hyper_intreg_o(cfg_hyper_intreg_o), .cfg_rw_hyper_o(cfg_rw_hyper_o),
    .cfg_addr_space_o(cfg_addr_space_o), .cfg_burst_type_o(cfg_burst_type_o),
    .cfg_twd_ext_act_o(cfg_twd_ext_act_o), .cfg_twd_ext_count_o(cfg_twd_ext_count_o),
    .cfg_twd_ext_stride_o(cfg_twd_ext_stride_o), .cfg_twd_l2_act_o(cfg_twd_l2_act_o),
    .cfg_twd_l2_count_o(cfg_twd_l2_count_o), .cfg_twd_l2_stride_o(cfg_twd_l2_stride_o),
    .cfg_rx_clr_o(cfg_rx_clr_o), .cfg_tx_clr_o(cfg_tx_clr_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // ---------------- reference model (register-map view) ----------------
  typedef struct { int ch; bit rx; } mdesc_t;
  typedef struct { bit ready; bit tvalid; bit [NCH-1:0] rxclr; bit [NCH-1:0] txclr; } cyc_t;
  typedef struct {
    int unsigned id, rx, saddr, size, cont, haddr, hcfg, rw, space, burst;
    int unsigned ea, ec, es, la, lc, ls;
  } pop_t;

  int unsigned    m_reg [NCH][16];
  mdesc_t         m_q[$];
  bit             m_pend [NCH];
  bit             m_err;
  bit [NCH-1:0]   m_rxclr, m_txclr;

  cyc_t           exp_cyc[$];
  logic [31:0]    exp_rd[$];
  pop_t           exp_pop[$];
  bit             mon_en = 1'b0;

  function automatic int unsigned reg_mask(input int idx);
    case (idx)
      0, 3:                   return 32'hFFF;
      1, 4, 8, 11, 12, 14, 15: return 32'hFFFF;
      2, 5, 10, 13:           return 32'h1;
      6:                      return 32'h7;
      7:                      return 32'hFFFF_FFFF;
      default:                return 32'h0;
    endcase
  endfunction

  function automatic bit is_lockable(input int idx);
    return (idx <= 8 && idx != 2 && idx != 5) || (idx >= 10 && idx <= 15);
  endfunction

  function automatic int unsigned pend_mask();
    int unsigned m = 0;
    for (int c = 0; c < NCH; c++) if (m_pend[c]) m |= (32'h1 << c);
    return m;
  endfunction

  function automatic logic [31:0] m_read(input int ch, input int idx, input bit bz);
    if (idx == 9)             return (pend_mask() << 16) | (32'(m_err) << 15) | (32'(m_q.size()) << 8) | 32'(bz);
    if (idx == 2 || idx == 5) return (32'(m_pend[ch]) << 5) | 32'h4 | m_reg[ch][idx];
    if (idx < 16)             return m_reg[ch][idx];
    return 32'h0;
  endfunction

  function automatic pop_t make_desc(input mdesc_t h);
    pop_t p;
    int c = h.ch;
    p.id = c; p.rx = h.rx;
    p.saddr = h.rx ? m_reg[c][0] : m_reg[c][3];
    p.size  = h.rx ? m_reg[c][1] : m_reg[c][4];
    p.cont  = h.rx ? m_reg[c][2] : m_reg[c][5];
    p.haddr = m_reg[c][7];  p.hcfg = m_reg[c][8];
    p.rw = (m_reg[c][6] >> 2) & 1; p.space = (m_reg[c][6] >> 1) & 1; p.burst = m_reg[c][6] & 1;
    p.ea = m_reg[c][10]; p.ec = m_reg[c][11]; p.es = m_reg[c][12];
    p.la = m_reg[c][13]; p.lc = m_reg[c][14]; p.ls = m_reg[c][15];
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 16; i++) m_reg[c][i] = 0;
      m_reg[c][6] = 32'h5;
      m_pend[c] = 1'b0;
    end
    m_q.delete();
    m_err = 1'b0; m_rxclr = '0; m_txclr = '0;
  endtask

  // One clock cycle: drive inputs, queue what the DUT must show, advance the model.
  task automatic step(input bit rst, input bit v, input bit rwn, input int ch, input int idx,
                      input logic [31:0] d, input bit tr, input bit bz, output bit rdy);
    bit tv, pop, wr, kick, pb;
    bit [NCH-1:0] nrx, ntx;
    mdesc_t hd;
    @(posedge clk); #1;
    rst_i = rst; cfg_valid_i = v; cfg_rwn_i = rwn; cfg_addr_i = 7'((ch << 5) | idx);
    cfg_data_i = d; trans_ready_i = tr; busy_i = bz;

    tv   = (m_q.size() != 0);
    pop  = tv && tr;
    wr   = v && !rwn;
    kick = wr && (idx == 2 || idx == 5) && d[4];
    rdy  = !(kick && m_q.size() == QD && !pop);
    exp_cyc.push_back('{rdy, tv, m_rxclr, m_txclr});
    if (v && rdy && rwn) exp_rd.push_back(m_read(ch, idx, bz));
    if (pop) begin hd = m_q[0]; exp_pop.push_back(make_desc(hd)); end
    if (rst) begin model_reset(); return; end

    nrx = '0; ntx = '0;
    pb  = m_pend[ch];
    if (pop) begin m_pend[hd.ch] = 1'b0; void'(m_q.pop_front()); end
    if (wr && rdy) begin
      if (is_lockable(idx)) begin
        if (pb) m_err = 1'b1;
        else    m_reg[ch][idx] = d & reg_mask(idx);
      end else if (idx == 2 || idx == 5) begin
        m_reg[ch][idx] = d & 32'h1;
        if (d[5]) begin if (idx == 2) nrx[ch] = 1'b1; else ntx[ch] = 1'b1; end
        if (d[4]) begin
          if (!pb || (pop && hd.ch == ch)) begin
            m_q.push_back('{ch, idx == 2});
            m_pend[ch] = 1'b1;
          end else m_err = 1'b1;
        end
      end else if (idx == 9 && d[15]) m_err = 1'b0;
    end
    m_rxclr = nrx; m_txclr = ntx;
  endtask

  // ---------------- monitor ----------------
  cyc_t mc;
  pop_t mp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_cyc.size() == 0) check("cycle_record_missing", 32'd0, 32'd1);
      else begin
        mc = exp_cyc.pop_front();
        check("cfg_ready_o",   32'(cfg_ready_o),   32'(mc.ready));
        check("trans_valid_o", 32'(trans_valid_o), 32'(mc.tvalid));
        check("cfg_rx_clr_o",  32'(cfg_rx_clr_o),  32'(mc.rxclr));
        check("cfg_tx_clr_o",  32'(cfg_tx_clr_o),  32'(mc.txclr));
      end
      if (cfg_valid_i && cfg_rwn_i && cfg_ready_o) begin
        if (exp_rd.size() == 0) check("read_unexpected", 32'd0, 32'd1);
        else check("cfg_data_o", cfg_data_o, exp_rd.pop_front());
      end
      if (trans_valid_o && trans_ready_i) begin
        if (exp_pop.size() == 0) check("pop_unexpected", 32'd0, 32'd1);
        else begin
          mp = exp_pop.pop_front();
          check("trans_id_o",       32'(trans_id_o),           mp.id);
          check("trans_rx_o",       32'(trans_rx_o),           mp.rx);
          check("cfg_startaddr_o",  32'(cfg_startaddr_o),      mp.saddr);
          check("cfg_size_o",       32'(cfg_size_o),           mp.size);
          check("cfg_continuous_o", 32'(cfg_continuous_o),     mp.cont);
          check("cfg_hyper_addr_o", cfg_hyper_addr_o,          mp.haddr);
          check("cfg_hyper_intreg", 32'(cfg_hyper_intreg_o),   mp.hcfg);
          check("cfg_rw_hyper_o",   32'(cfg_rw_hyper_o),       mp.rw);
          check("cfg_addr_space_o", 32'(cfg_addr_space_o),     mp.space);
          check("cfg_burst_type_o", 32'(cfg_burst_type_o),     mp.burst);
          check("twd_ext_act",      32'(cfg_twd_ext_act_o),    mp.ea);
          check("twd_ext_count",    32'(cfg_twd_ext_count_o),  mp.ec);
          check("twd_ext_stride",   32'(cfg_twd_ext_stride_o), mp.es);
          check("twd_l2_act",       32'(cfg_twd_l2_act_o),     mp.la);
          check("twd_l2_count",     32'(cfg_twd_l2_count_o),   mp.lc);
          check("twd_l2_stride",    32'(cfg_twd_l2_stride_o),  mp.ls);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  bit r;
  task automatic wr(input int ch, input int idx, input logic [31:0] d, input bit tr = 1'b0);
    step(1'b0, 1'b1, 1'b0, ch, idx, d, tr, 1'b0, r);
  endtask
  task automatic rd(input int ch, input int idx, input bit bz = 1'b0);
    step(1'b0, 1'b1, 1'b1, ch, idx, 32'h0, 1'b0, bz, r);
  endtask
  task automatic idle(input int n, input bit tr);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, tr, 1'b0, r);
  endtask

  initial begin
    bit hold, v, rwn, rst, tr, bz;
    int ch, idx;
    logic [31:0] d;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, r);
    @(negedge clk); #1;
    exp_cyc.delete();
    mon_en = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, r);

    // reset values
    rd(0, 6); rd(3, 9, 1'b1); rd(1, 2);

    // single RX kick on ch2, then consume it
    wr(2, 0, 32'h120); wr(2, 1, 32'h40); wr(2, 2, 32'h10);
    rd(1, 9); rd(2, 2);
    idle(1, 1'b1);

    // fill the queue with TX kicks, stall a fifth, release it with a pop of ch0
    for (int c = 0; c < NCH; c++) wr(c, 5, 32'h10);
    rd(0, 9);
    step(1'b0, 1'b1, 1'b0, 0, 2, 32'h10, 1'b0, 1'b0, r);
    step(1'b0, 1'b1, 1'b0, 0, 2, 32'h10, 1'b0, 1'b0, r);
    step(1'b0, 1'b1, 1'b0, 0, 2, 32'h10, 1'b1, 1'b0, r);
    rd(2, 9);

    // lock on a pending bank, then W1C of err
    wr(1, 7, 32'hDEAD); rd(1, 7); rd(3, 9);
    wr(2, 9, 32'h0000_7FFF); rd(0, 9);
    wr(0, 9, 32'h8000); rd(1, 9);

    // re-kick ch3 in the cycle its descriptor pops
    idle(2, 1'b1);
    wr(3, 5, 32'h11, 1'b1);
    rd(0, 9); rd(3, 5);
    idle(3, 1'b1);

    // clear pulse without a push
    wr(1, 2, 32'h20); idle(2, 1'b0); rd(1, 9);

    // reset with three descriptors queued
    wr(2, 6, 32'h2);
    wr(0, 5, 32'h10); wr(1, 5, 32'h10); wr(2, 5, 32'h10);
    step(1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, r);
    rd(0, 9, 1'b1); rd(2, 6); rd(2, 5);

    // randomized traffic, holding any stalled request until accepted
    hold = 1'b0; v = 0; rwn = 0; ch = 0; idx = 0; d = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 99) < 60);
        rwn = $urandom_range(0, 1);
        ch  = $urandom_range(0, NCH - 1);
        case ($urandom_range(0, 9))
          0:       idx = $urandom_range(16, 31);
          1, 2, 3: idx = 2;
          4, 5:    idx = 5;
          6:       idx = 9;
          default: idx = $urandom_range(0, 15);
        endcase
        d = $urandom();
      end
      rst = !hold && ($urandom_range(0, 399) == 0);
      tr  = !rst && ($urandom_range(0, 99) < 30);
      bz  = $urandom_range(0, 1);
      step(rst, rst ? 1'b0 : v, rwn, ch, idx, d, tr, bz, r);
      hold = v && !rst && !r;
    end

    idle(QD + 2, 1'b1);
    @(negedge clk); #1;
    mon_en = 1'b0;
    check("leftover_cycle_records", 32'(exp_cyc.size()), 32'd0);
    check("leftover_reads",         32'(exp_rd.size()),  32'd0);
    check("leftover_pops",          32'(exp_pop.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
